dfx_pkt_encap: RTL and testbench
================================

Name: dfx_pkt_encap

Overview:
- Packet encapsulator directly upstream of the router controller's input port 0.
- Requests a header from the router controller by pulsing ready_encap_dfx, latches the returned 9-bit header and destination address one cycle later, and builds a frame.
- The frame is one header word followed by PAYLOAD_WORDS payload words pulled from the DFX payload stream. It is pushed into the input-port-0 FIFO through a valid/ready interface.

Parameters:
- AURORA_DATA_WIDTH, 64, frame word width; must be >= 32.
- ADDR_WIDTH, 10, destination address width.
- PAYLOAD_WORDS, 4, payload words per frame; range 1..255.
- SOF_MAGIC, 8'hA5, marker placed in header word bits [63:56].

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- encap_en  in  1  level enable; frames are built only while high.
- ready_encap_dfx  out  1  one-cycle header request pulse to the router controller.
- header_pkt_in  in  9  {TTL[8:7], pkt_num[6:2], src_router[1:0]} from the router controller.
- dst_addr_in  in  ADDR_WIDTH  destination address from the router controller.
- pl_data  in  AURORA_DATA_WIDTH  payload word.
- pl_valid  in  1  payload word valid.
- pl_ready  out  1  payload word accepted when pl_valid && pl_ready.
- tx_data  out  AURORA_DATA_WIDTH  frame word to the input-port-0 FIFO.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  FIFO can accept; this is the inverse of FIFO full.
- tx_sof  out  1  marks the header word.
- tx_eof  out  1  marks the last word of the frame.
- busy  out  1  high in any state other than IDLE.
- frame_count  out  16  number of completed frames; wraps from 16'hFFFF to 0.

Behaviour:
- Reset, synchronous, rst_n low at posedge:
  - state = IDLE.
  - All outputs 0; frame_count = 0.
  - Word counter and latched header/address cleared.
  - Applies mid-frame: the partial frame is abandoned and no eof is emitted.
- Header word layout:
  - [63:56] SOF_MAGIC.
  - [55:ADDR_WIDTH+9] zero.
  - [ADDR_WIDTH+8:9] dst_addr.
  - [8:0] header.
  - TTL therefore sits at [8:7], where the router controller decrements it.
- FSM states and transitions:
  - IDLE: if encap_en, go to REQ. Otherwise stay.
  - REQ: ready_encap_dfx = 1 for exactly this cycle, then go to LATCH.
  - LATCH: capture header_pkt_in and dst_addr_in (the controller registers them on the request cycle, so they are valid here), then go to HDR.
  - HDR: tx_valid = 1, tx_sof = 1, tx_data = header word. Hold until tx_ready, then go to PAY with word counter = 0.
  - PAY: pl_ready = tx_ready; tx_valid = pl_valid; tx_data = pl_data (combinational pass-through, zero added latency).
    - On each transfer (pl_valid && tx_ready), increment the counter.
    - tx_eof = 1 when counter == PAYLOAD_WORDS-1 (and checksum is off).
    - On the last transfer, frame_count += 1. Then go to REQ if encap_en is still high, else IDLE.
- encap_en deasserted mid-frame: the current frame completes; no new request is made.
- Backpressure:
  - tx_data, tx_sof and tx_eof hold stable while tx_valid && !tx_ready.
  - No payload word is consumed unless it is written to the FIFO in the same cycle.
- Payload starvation (pl_valid = 0 in PAY): tx_valid = 0, no timeout, wait indefinitely.
- Simultaneous events: if pl_valid and tx_ready are both high on the last word and encap_en is high, the next state is REQ (gap of 2 cycles before the next HDR).
- Minimum frame period: PAYLOAD_WORDS + 3 cycles under no stalls.

Optional Feature:
- Macro: ENCAP_CHECKSUM_EN.
- When defined:
  - PAY exits to CSUM instead of finishing, and tx_eof is not set in PAY.
  - A running XOR of all transferred payload words is kept; it is cleared in LATCH.
  - CSUM: tx_valid = 1, tx_eof = 1, tx_data = XOR. Hold until tx_ready; frame_count increments on this transfer.
  - Frame length is PAYLOAD_WORDS + 2.
- When undefined: no CSUM state and no XOR register. The last payload word carries tx_eof.

Test Plan:
1. Reset, then encap_en = 1, tx_ready = 1, pl_valid = 1 continuous, header_pkt_in = 9'h10A, dst_addr_in = 10'h155 -> ready_encap_dfx pulses 1 cycle; next-but-one cycle header word = 64'hA500_0000_0002_AB0A with sof = 1; then 4 payload words, eof on the 4th; frame_count = 1.
2. tx_ready low for 3 cycles during HDR and during payload word 2 -> tx_data held stable; pl_ready = 0 for those cycles; no word lost or duplicated.
3. pl_valid drops for 5 cycles mid-payload -> tx_valid = 0 in those cycles; frame resumes at the same word index; eof still on the 4th word.
4. encap_en low after 2 payload words -> frame completes, FSM returns to IDLE, no further ready_encap_dfx pulse; busy = 0.
5. rst_n low during payload word 2, then encap_en = 1 -> all outputs 0 on reset; next frame starts with a fresh request and sof; frame_count = 0.
6. ENCAP_CHECKSUM_EN defined, payload words 1, 2, 4, 8 -> a 6th word equal to 64'hF with eof = 1; frame_count increments only after it.

Source files
------------

// File: rtl/dfx_pkt_encap.sv
// Packet encapsulator feeding router input port 0: requests a header, then emits header + payload frame.
// Optional build macro ENCAP_CHECKSUM_EN appends an XOR checksum word after the payload.
module dfx_pkt_encap #(
  parameter int          AURORA_DATA_WIDTH = 64,
  parameter int          ADDR_WIDTH        = 10,
  parameter int          PAYLOAD_WORDS     = 4,
  parameter logic [7:0]  SOF_MAGIC         = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         encap_en,
  output logic                         ready_encap_dfx,
  input  logic [8:0]                   header_pkt_in,
  input  logic [ADDR_WIDTH-1:0]        dst_addr_in,
  input  logic [AURORA_DATA_WIDTH-1:0] pl_data,
  input  logic                         pl_valid,
  output logic                         pl_ready,
  output logic [AURORA_DATA_WIDTH-1:0] tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         tx_sof,
  output logic                         tx_eof,
  output logic                         busy,
  output logic [15:0]                  frame_count
);

  // state | meaning
  // IDLE  | waiting for encap_en
  // REQ   | header request pulse to router controller
  // LATCH | capture header and destination address
  // HDR   | present header word until accepted
  // PAY   | pass payload words straight through to the FIFO
  // CSUM  | present XOR checksum word (checksum build only)
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LATCH,
    HDR,
`ifdef ENCAP_CHECKSUM_EN
    PAY,
    CSUM
`else
    PAY
`endif
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_WORDS - 1);

  state_t                 state;
  logic [7:0]             cnt;
  logic [8:0]             hdr_q;
  logic [ADDR_WIDTH-1:0]  dst_q;
  logic [AURORA_DATA_WIDTH-1:0] hdr_word;
  logic                   last;
`ifdef ENCAP_CHECKSUM_EN
  logic [AURORA_DATA_WIDTH-1:0] csum_q;
`endif

  assign last = (cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hdr_q       <= '0;
      dst_q       <= '0;
      frame_count <= '0;
`ifdef ENCAP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (encap_en) state <= REQ;
        REQ:  state <= LATCH;
        LATCH: begin
          hdr_q  <= header_pkt_in;
          dst_q  <= dst_addr_in;
`ifdef ENCAP_CHECKSUM_EN
          csum_q <= '0;
`endif
          state  <= HDR;
        end
        HDR: if (tx_ready) begin
          cnt   <= '0;
          state <= PAY;
        end
        PAY: if (pl_valid && tx_ready) begin
          cnt <= cnt + 8'd1;
`ifdef ENCAP_CHECKSUM_EN
          csum_q <= csum_q ^ pl_data;
          if (last) state <= CSUM;
`else
          if (last) begin
            frame_count <= frame_count + 16'd1;
            state       <= encap_en ? REQ : IDLE;
          end
`endif
        end
`ifdef ENCAP_CHECKSUM_EN
        CSUM: if (tx_ready) begin
          frame_count <= frame_count + 16'd1;
          state       <= encap_en ? REQ : IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hdr_word = '0;
    hdr_word[AURORA_DATA_WIDTH-1 -: 8] = SOF_MAGIC;
    hdr_word[ADDR_WIDTH+8:0]           = {dst_q, hdr_q};
  end

  // Outputs decode directly from the state register; PAY is a zero-latency pass-through.
  always_comb begin
    ready_encap_dfx = (state == REQ);
    busy            = (state != IDLE);
    tx_valid        = 1'b0;
    tx_sof          = 1'b0;
    tx_eof          = 1'b0;
    tx_data         = '0;
    pl_ready        = 1'b0;
    case (state)
      HDR: begin
        tx_valid = 1'b1;
        tx_sof   = 1'b1;
        tx_data  = hdr_word;
      end
      PAY: begin
        tx_valid = pl_valid;
        tx_data  = pl_data;
        pl_ready = tx_ready;
`ifndef ENCAP_CHECKSUM_EN
        tx_eof   = pl_valid && last;
`endif
      end
`ifdef ENCAP_CHECKSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_eof   = 1'b1;
        tx_data  = csum_q;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dfx_pkt_encap.sv
// Scoreboard bench for dfx_pkt_encap: frames are queued at each header request, a monitor checks FIFO writes.
module tb_dfx_pkt_encap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        encap_en = 1'b0;
  logic        ready_encap_dfx;
  logic [8:0]  header_pkt_in = '0;
  logic [9:0]  dst_addr_in = '0;
  logic [63:0] pl_data;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_sof;
  logic        tx_eof;
  logic        busy;
  logic [15:0] frame_count;

  dfx_pkt_encap dut (
    .clk(clk), .rst_n(rst_n), .encap_en(encap_en), .ready_encap_dfx(ready_encap_dfx),
    .header_pkt_in(header_pkt_in), .dst_addr_in(dst_addr_in),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        sof;
    logic        eof;
  } word_t;

  word_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int pl_seq = 0;
  int exp_seq = 0;
  int req_cnt = 0;
  bit pl_fire;

  function automatic logic [63:0] mk(input int s);
`ifdef ENCAP_CHECKSUM_EN
    return 64'h1 << (s % 4);
`else
    return {32'hC0DE_0000 + 32'(s), (32'(s) * 32'h0101_0101) ^ 32'h5A5A_0F0F};
`endif
  endfunction

  function automatic logic [63:0] exp_hdr(input logic [8:0] h, input logic [9:0] d);
    return {8'hA5, 37'd0, d, h};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_encap_dfx) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 64'(ok), 64'd1);
  endtask

  // Payload source: advances to the next word only after an accepted transfer.
  initial pl_data = mk(0);
  always begin
    @(negedge clk);
    pl_fire = rst_n && pl_valid && pl_ready;
    @(posedge clk);
    #1;
    if (pl_fire) begin
      pl_seq++;
      pl_data = mk(pl_seq);
    end
  end

  // Each header request queues the complete frame the DUT must emit.
  always @(negedge clk) begin
    if (rst_n && ready_encap_dfx) begin
      word_t w;
      req_cnt++;
      w.d = exp_hdr(header_pkt_in, dst_addr_in); w.sof = 1'b1; w.eof = 1'b0;
      exp_q.push_back(w);
      for (int i = 0; i < 4; i++) begin
        w.d = mk(exp_seq); w.sof = 1'b0;
`ifdef ENCAP_CHECKSUM_EN
        w.eof = 1'b0;
`else
        w.eof = (i == 3);
`endif
        exp_q.push_back(w);
        exp_seq++;
      end
`ifdef ENCAP_CHECKSUM_EN
      w.d = 64'h0000_0000_0000_000F; w.sof = 1'b0; w.eof = 1'b1;
      exp_q.push_back(w);
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      word_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got data=%h sof=%b eof=%b expected no word", tx_data, tx_sof, tx_eof);
      end else begin
        e = exp_q.pop_front();
        if ({tx_data, tx_sof, tx_eof} !== e) begin
          n_err++;
          $display("FAIL tx_word: got data=%h sof=%b eof=%b expected data=%h sof=%b eof=%b",
                   tx_data, tx_sof, tx_eof, e.d, e.sof, e.eof);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    @(negedge clk);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_req", 64'(ready_encap_dfx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fc", 64'(frame_count), 64'd0);
    check("rst_pl_ready", 64'(pl_ready), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: basic frame
    header_pkt_in = 9'h10A; dst_addr_in = 10'h155;
    tx_ready = 1'b1; pl_valid = 1'b1; encap_en = 1'b1;
    wait_req();
    step(); encap_en = 1'b0;
    @(negedge clk);
    check("req_one_cycle", 64'(ready_encap_dfx), 64'd0);
    step();
    @(negedge clk);
    check("t1_sof", 64'(tx_sof), 64'd1);
    check("t1_hdr", tx_data, 64'hA500_0000_0002_AB0A);
    wait_idle();
    check("t1_fc", 64'(frame_count), 64'd1);

    // 2: backpressure on header and on payload word 2
    header_pkt_in = 9'h1FF; dst_addr_in = 10'h3FF; encap_en = 1'b1;
    wait_req();
    step(); encap_en = 1'b0; tx_ready = 1'b0;
    step();
    repeat (3) begin
      @(negedge clk);
      check("t2_hdr_hold", tx_data, 64'hA500_0000_0007_FFFF);
      check("t2_hdr_plr", 64'(pl_ready), 64'd0);
      step();
    end
    tx_ready = 1'b1;
    step();
    step();
    tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t2_pay_hold", tx_data, mk(exp_seq - 3));
      check("t2_pay_plr", 64'(pl_ready), 64'd0);
      step();
    end
    tx_ready = 1'b1;
    wait_idle();
    check("t2_fc", 64'(frame_count), 64'd2);

    // 3: payload starvation after two words
    header_pkt_in = 9'h0A5; dst_addr_in = 10'h001; encap_en = 1'b1;
    wait_req();
    step(); encap_en = 1'b0;
    repeat (4) step();
    pl_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t3_starve_valid", 64'(tx_valid), 64'd0);
      step();
    end
    pl_valid = 1'b1;
    wait_idle();
    check("t3_fc", 64'(frame_count), 64'd3);

    // 4: enable dropped mid-frame
    header_pkt_in = 9'h155; dst_addr_in = 10'h2AA; encap_en = 1'b1;
    wait_req();
    repeat (5) step();
    encap_en = 1'b0;
    req_cnt = 0;
    wait_idle();
    repeat (10) @(negedge clk);
    check("t4_no_req", 64'(req_cnt), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_fc", 64'(frame_count), 64'd4);

    // 5: reset during payload word 2
    header_pkt_in = 9'h0F0; dst_addr_in = 10'h0F0; encap_en = 1'b1;
    wait_req();
    repeat (4) step();
    rst_n = 1'b0; encap_en = 1'b0;
    step();
    @(negedge clk);
    check("t5_valid", 64'(tx_valid), 64'd0);
    check("t5_eof", 64'(tx_eof), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_plr", 64'(pl_ready), 64'd0);
    check("t5_fc", 64'(frame_count), 64'd0);
    step();
    rst_n = 1'b1;
    exp_q.delete();
    exp_seq = pl_seq;
    encap_en = 1'b1;
    wait_req();
    step(); encap_en = 1'b0;
    step();
    @(negedge clk);
    check("t5_sof", 64'(tx_sof), 64'd1);
    wait_idle();
    check("t5_fc_after", 64'(frame_count), 64'd1);

    repeat (5) @(negedge clk);
    check("q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
